// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: video > host > optional blitter, with a return tag to route read data.
// Define VRAM_ARB_BLIT_EN to add the blitter port.
module vram_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_sel,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_busy,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
`ifdef VRAM_ARB_BLIT_EN
  input  logic              blit_req,
  input  logic              blit_wr,
  input  logic [ADDR_W-1:0] blit_addr,
  input  logic [DATA_W-1:0] blit_wdata,
  output logic              blit_ack,
  output logic [DATA_W-1:0] blit_rdata,
`endif
  output logic              vram_sel,
  output logic              vram_wr_en,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_HOST, TAG_BLIT} tag_e;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } host_req_t;

  host_req_t hreq;
  logic      host_pend;
  logic      host_cap;
  logic      blit_go;
  logic      tag_wr;
  tag_e      tag;
  tag_e      grant;

  assign host_cap  = host_req & ~host_busy;
  assign host_busy = host_pend | (tag == TAG_HOST);
  assign host_ack  = (tag == TAG_HOST);
  assign vid_valid = (tag == TAG_VID);
  assign vid_data  = vram_rdata;

`ifdef VRAM_ARB_BLIT_EN
  // A host request arriving this cycle outranks the blitter even before it is latched.
  assign blit_go    = blit_req & ~host_cap;
  assign blit_ack   = (tag == TAG_BLIT);
  assign blit_rdata = vram_rdata;
`else
  assign blit_go    = 1'b0;
`endif

  always_comb begin
    grant = TAG_NONE;
    if (vid_sel)        grant = TAG_VID;
    else if (host_pend) grant = TAG_HOST;
    else if (blit_go)   grant = TAG_BLIT;
  end

  always_comb begin
    vram_sel   = 1'b0;
    vram_wr_en = 1'b0;
    vram_addr  = '0;
    vram_wdata = '0;
    case (grant)
      TAG_VID: begin
        vram_sel  = 1'b1;
        vram_addr = vid_addr;
      end
      TAG_HOST: begin
        vram_sel   = 1'b1;
        vram_wr_en = hreq.wr;
        vram_addr  = hreq.addr;
        vram_wdata = hreq.wdata;
      end
`ifdef VRAM_ARB_BLIT_EN
      TAG_BLIT: begin
        vram_sel   = 1'b1;
        vram_wr_en = blit_wr;
        vram_addr  = blit_addr;
        vram_wdata = blit_wdata;
      end
`endif
      default: ;
    endcase
    // Keep the VRAM quiet for the whole reset window, not just after the first edge.
    if (reset) begin
      vram_sel   = 1'b0;
      vram_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host_pend  <= 1'b0;
      hreq       <= '0;
      tag        <= TAG_NONE;
      tag_wr     <= 1'b0;
      host_rdata <= '0;
    end else begin
      if (host_cap) begin
        host_pend  <= 1'b1;
        hreq.wr    <= host_wr;
        hreq.addr  <= host_addr;
        hreq.wdata <= host_wdata;
      end else if (grant == TAG_HOST) begin
        host_pend <= 1'b0;
      end
      tag    <= grant;
      tag_wr <= vram_wr_en;
      if (tag == TAG_HOST && !tag_wr)
        host_rdata <= vram_rdata;
    end
  end

endmodule

// File: tb/tb_vram_arb.sv
// Randomized bench for vram_arb: a VRAM model plus a transaction-level reference
// (shadow memory, pending host request, expected returns) checked every cycle.
module tb_vram_arb;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          vid_sel;
  logic [AW-1:0] vid_addr;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          host_req, host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_busy, host_ack;
  logic [DW-1:0] host_rdata;
  logic          blit_req = 1'b0, blit_wr = 1'b0;
  logic [AW-1:0] blit_addr = '0;
  logic [DW-1:0] blit_wdata = '0;
  logic          blit_ack;
  logic [DW-1:0] blit_rdata;
  logic          vram_sel, vram_wr_en;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_wdata;
  logic [DW-1:0] vram_rdata = '0;

  always #5 clk = ~clk;

  vram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .vid_sel(vid_sel), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_busy(host_busy), .host_ack(host_ack), .host_rdata(host_rdata),
`ifdef VRAM_ARB_BLIT_EN
    .blit_req(blit_req), .blit_wr(blit_wr), .blit_addr(blit_addr), .blit_wdata(blit_wdata),
    .blit_ack(blit_ack), .blit_rdata(blit_rdata),
`endif
    .vram_sel(vram_sel), .vram_wr_en(vram_wr_en), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
  );

`ifndef VRAM_ARB_BLIT_EN
  assign blit_ack   = 1'b0;
  assign blit_rdata = '0;
`endif

  // VRAM: synchronous write, registered read data
  logic [DW-1:0] vram_mem [0:65535];
  always @(posedge clk)
    if (vram_sel) begin
      if (vram_wr_en) vram_mem[vram_addr] <= vram_wdata;
      else            vram_rdata <= vram_mem[vram_addr];
    end

  // reference state
  logic [DW-1:0] m_mem [0:65535];
  logic          m_pend, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_hack, m_hack_rd;
  logic [DW-1:0] m_hack_val, m_rdata;
  logic          m_vid;
  logic [DW-1:0] m_vid_val;
  logic          m_back, m_back_rd;
  logic [DW-1:0] m_back_val;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
    m_hack = 0; m_hack_rd = 0; m_hack_val = 0; m_rdata = 0;
    m_vid = 0; m_vid_val = 0;
    m_back = 0; m_back_rd = 0; m_back_val = 0;
  endtask

  // One clock cycle: drive after the falling edge, check, then advance the reference.
  task automatic step(input logic vs, input logic [AW-1:0] va, input logic hr,
                      input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    logic          busy, cap;
    int            own;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    @(negedge clk);
    vid_sel = vs; vid_addr = va;
    host_req = hr; host_wr = hw; host_addr = ha; host_wdata = hd;
    #1;
    busy = m_pend | m_hack;
    cap  = hr & ~busy;
    own  = vs ? 1 : m_pend ? 2 : (blit_req & ~cap) ? 3 : 0;
`ifndef VRAM_ARB_BLIT_EN
    if (own == 3) own = 0;
`endif
    e_wr   = (own == 2) ? m_wr : (own == 3) ? blit_wr : 1'b0;
    e_addr = (own == 1) ? va : (own == 2) ? m_addr : (own == 3) ? blit_addr : '0;
    e_wd   = (own == 2) ? m_wdata : (own == 3) ? blit_wdata : '0;
    chk("vram_sel", vram_sel, own != 0);
    chk("vram_wr_en", vram_wr_en, e_wr);
    chk("vram_addr", vram_addr, e_addr);
    chk("vram_wdata", vram_wdata, e_wd);
    chk("host_busy", host_busy, busy);
    chk("host_ack", host_ack, m_hack);
    chk("host_rdata", host_rdata, m_rdata);
    chk("vid_valid", vid_valid, m_vid);
    if (m_vid) chk("vid_data", vid_data, m_vid_val);
`ifdef VRAM_ARB_BLIT_EN
    chk("blit_ack", blit_ack, m_back);
    if (m_back && m_back_rd) chk("blit_rdata", blit_rdata, m_back_val);
`endif
    if (m_hack && m_hack_rd) m_rdata = m_hack_val;
    m_vid = vs;
    if (vs) m_vid_val = m_mem[va];
    m_hack = (own == 2);
    if (own == 2) begin
      m_hack_rd  = ~m_wr;
      m_hack_val = m_mem[m_addr];
      if (m_wr) m_mem[m_addr] = m_wdata;
      m_pend = 0;
    end
    m_back = (own == 3);
    if (own == 3) begin
      m_back_rd  = ~blit_wr;
      m_back_val = m_mem[blit_addr];
      if (blit_wr) m_mem[blit_addr] = blit_wdata;
    end
    if (cap) begin
      m_pend = 1; m_wr = hw; m_addr = ha; m_wdata = hd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [AW-1:0] a;
    a = $urandom_range(0, 7);
    if ($urandom_range(0, 1) == 1) a = a | 16'h4000;
    return a;
  endfunction

  int n_ack;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      vram_mem[i] = 16'hDEAD;
      m_mem[i]    = 16'hDEAD;
    end
    model_reset();
    reset = 1; vid_sel = 1; vid_addr = 16'h0005;
    host_req = 0; host_wr = 0; host_addr = 0; host_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_vram_sel", vram_sel, 1'b0);
    chk("rst_vram_wr_en", vram_wr_en, 1'b0);
    chk("rst_host_busy", host_busy, 1'b0);
    chk("rst_host_ack", host_ack, 1'b0);
    chk("rst_vid_valid", vid_valid, 1'b0);
    chk("rst_host_rdata", host_rdata, 16'h0);
    @(posedge clk); #2 reset = 0;
    step(1, 16'h0005, 0, 0, '0, '0);
    chk("rel_vram_sel", vram_sel, 1'b1);

    // video stream over unwritten words
    for (int i = 0; i < 4; i++) begin
      step(1, AW'(i), 0, 0, '0, '0);
      if (i == 1) chk("vid_dead", vid_data, 16'hDEAD);
    end
    idle(1);

    // host write then read back
    step(0, '0, 1, 1, 16'h4000, 16'h1234);
    idle(2);
    step(0, '0, 1, 0, 16'h4000, '0);
    idle(3);
    chk("host_rd_1234", host_rdata, 16'h1234);

    // contention: host read waits behind 10 video cycles, extra host_req ignored
    n_ack = 0;
    step(0, '0, 1, 0, 16'h4000, '0);
    for (int i = 0; i < 10; i++) begin
      step(1, AW'(i), 1, 1, 16'h0003, 16'h5555);
      n_ack += int'(host_ack);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0, 0, '0, '0);
      n_ack += int'(host_ack);
    end
    chk("one_ack", n_ack, 1);
    chk("contend_rdata", host_rdata, 16'h1234);

    // reset in the cycle after a host grant
    step(0, '0, 1, 0, 16'h0002, '0);
    idle(1);
    @(negedge clk); reset = 1; #1;
    chk("mid_host_ack", host_ack, 1'b0);
    chk("mid_host_busy", host_busy, 1'b0);
    chk("mid_host_rdata", host_rdata, 16'h0);
    model_reset();
    @(posedge clk); #2 reset = 0;
    idle(2);

`ifdef VRAM_ARB_BLIT_EN
    // new host request beats a simultaneous blitter request
    blit_req = 1; blit_wr = 1; blit_addr = 16'hC001; blit_wdata = 16'hBEEF;
    step(0, '0, 1, 0, 16'h0001, '0);
    chk("blit_blocked", vram_wr_en, 1'b0);
    idle(2);
    chk("blit_after_host", host_ack, 1'b1);
    blit_req = 0;
    step(0, '0, 0, 0, '0, '0);
    chk("blit_ack_seen", blit_ack, 1'b1);
    step(0, '0, 1, 0, 16'hC001, '0);
    idle(3);
    chk("blit_readback", host_rdata, 16'hBEEF);
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      logic vs;
`ifdef VRAM_ARB_BLIT_EN
      if (!blit_req || m_back) begin
        blit_req   = ($urandom_range(0, 99) < 30);
        blit_wr    = $urandom_range(0, 1);
        blit_addr  = rnd_addr();
        blit_wdata = DW'($urandom);
      end
`endif
      vs = ($urandom_range(0, 99) < 55);
      step(vs, rnd_addr(), $urandom_range(0, 99) < 30, $urandom_range(0, 1),
           rnd_addr(), DW'($urandom));
    end
    blit_req = 0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, limit reached");
    $fatal(1, "timeout");
  end
endmodule
